memory_stage: RTL and testbench

//   Pipeline memory stage, directly downstream of the execute stage. Consumes the
//   id_mem_* bundle, performs load/store over a req/ack data-memory port, selects
//   the write-back value and registers the bundle for the write-back stage.

---
 rtl/memory_stage.sv | 172 +++++++++++++++++
 tb/tb_memory_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Pipeline memory stage: load/store over a req/ack data port, write-back select and staging.
// Optional `MEM_TIMEOUT_EN aborts a BUSY access after TIMEOUT cycles without mem_ack.
module memory_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_mem_readmem,
  input  logic        id_mem_writemem,
  input  logic [31:0] id_mem_regb,
  input  logic        id_mem_selwsource,
  input  logic [4:0]  id_mem_regdest,
  input  logic        id_mem_writereg,
  input  logic [31:0] id_mem_wbvalue,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_req,
  output logic        mem_wr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        mem_wb_writereg,
  output logic [4:0]  mem_wb_regdest,
  output logic [31:0] mem_wb_value,
  output logic        mem_buserr
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wb_writereg_q, wb_writereg_d;
  logic [4:0]  wb_regdest_q, wb_regdest_d;
  logic [31:0] wb_value_q, wb_value_d;
  logic [4:0]  hold_regdest_q, hold_regdest_d;
  logic        hold_writereg_q, hold_writereg_d;
  logic        hold_sel_q, hold_sel_d;
  logic        memop;
  logic        timeout;

  assign memop = id_mem_readmem | id_mem_writemem;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            buserr_q, buserr_d;

  assign timeout    = (cnt_q == CntW'(TIMEOUT - 1));
  assign mem_buserr = buserr_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign timeout        = 1'b0;
  assign mem_buserr     = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    req_d           = req_q;
    wr_d            = wr_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    wb_writereg_d   = wb_writereg_q;
    wb_regdest_d    = wb_regdest_q;
    wb_value_d      = wb_value_q;
    hold_regdest_d  = hold_regdest_q;
    hold_writereg_d = hold_writereg_q;
    hold_sel_d      = hold_sel_q;
    mem_stall       = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d           = cnt_q;
    buserr_d        = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (memop) begin
          mem_stall       = 1'b1;
          hold_regdest_d  = id_mem_regdest;
          hold_writereg_d = id_mem_writereg;
          hold_sel_d      = id_mem_selwsource;
          addr_d          = id_mem_wbvalue;
          wdata_d         = id_mem_regb;
          wr_d            = id_mem_writemem;  // read+write together is a store
          req_d           = 1'b1;
          wb_writereg_d   = 1'b0;
`ifdef MEM_TIMEOUT_EN
          cnt_d           = '0;
`endif
          state_d         = StBusy;
        end else begin
          wb_writereg_d = id_mem_writereg;
          wb_regdest_d  = id_mem_regdest;
          wb_value_d    = id_mem_wbvalue;
        end
      end
      StBusy: begin
        if (mem_ack) begin
          // Ack wins over a coincident timeout.
          req_d         = 1'b0;
          wb_writereg_d = hold_writereg_q;
          wb_regdest_d  = hold_regdest_q;
          wb_value_d    = (!wr_q && hold_sel_q) ? mem_rdata : addr_q;
          state_d       = StIdle;
        end else if (timeout) begin
          req_d         = 1'b0;
          wb_writereg_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
          buserr_d      = 1'b1;
`endif
          state_d       = StIdle;
        end else begin
          mem_stall     = 1'b1;
          wb_writereg_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
          cnt_d         = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= StIdle;
      req_q           <= 1'b0;
      wr_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      wb_writereg_q   <= 1'b0;
      wb_regdest_q    <= '0;
      wb_value_q      <= '0;
      hold_regdest_q  <= '0;
      hold_writereg_q <= 1'b0;
      hold_sel_q      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q           <= '0;
      buserr_q        <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      req_q           <= req_d;
      wr_q            <= wr_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      wb_writereg_q   <= wb_writereg_d;
      wb_regdest_q    <= wb_regdest_d;
      wb_value_q      <= wb_value_d;
      hold_regdest_q  <= hold_regdest_d;
      hold_writereg_q <= hold_writereg_d;
      hold_sel_q      <= hold_sel_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q           <= cnt_d;
      buserr_q        <= buserr_d;
`endif
    end
  end

  assign mem_req         = req_q;
  assign mem_wr          = wr_q;
  assign mem_addr        = addr_q;
  assign mem_wdata       = wdata_q;
  assign mem_wb_writereg = wb_writereg_q;
  assign mem_wb_regdest  = wb_regdest_q;
  assign mem_wb_value    = wb_value_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: scripted ALU/load/store traffic, write-back scoreboard,
// reset-mid-access and (with MEM_TIMEOUT_EN) timeout abort.
module tb_memory_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        id_mem_readmem = 1'b0;
  logic        id_mem_writemem = 1'b0;
  logic [31:0] id_mem_regb = '0;
  logic        id_mem_selwsource = 1'b0;
  logic [4:0]  id_mem_regdest = '0;
  logic        id_mem_writereg = 1'b0;
  logic [31:0] id_mem_wbvalue = '0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_req;
  logic        mem_wr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_stall;
  logic        mem_wb_writereg;
  logic [4:0]  mem_wb_regdest;
  logic [31:0] mem_wb_value;
  logic        mem_buserr;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_pop = 0;
  int          prev_pop = 0;
  logic [36:0] exp_q[$];

  memory_stage #(.TIMEOUT(16)) dut (
    .clock             (clock),
    .reset             (reset),
    .id_mem_readmem    (id_mem_readmem),
    .id_mem_writemem   (id_mem_writemem),
    .id_mem_regb       (id_mem_regb),
    .id_mem_selwsource (id_mem_selwsource),
    .id_mem_regdest    (id_mem_regdest),
    .id_mem_writereg   (id_mem_writereg),
    .id_mem_wbvalue    (id_mem_wbvalue),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_req           (mem_req),
    .mem_wr            (mem_wr),
    .mem_ack           (mem_ack),
    .mem_rdata         (mem_rdata),
    .mem_stall         (mem_stall),
    .mem_wb_writereg   (mem_wb_writereg),
    .mem_wb_regdest    (mem_wb_regdest),
    .mem_wb_value      (mem_wb_value),
    .mem_buserr        (mem_buserr)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_nop();
    id_mem_readmem    = 1'b0;
    id_mem_writemem   = 1'b0;
    id_mem_selwsource = 1'b0;
    id_mem_writereg   = 1'b0;
    id_mem_regdest    = '0;
    id_mem_wbvalue    = '0;
    id_mem_regb       = '0;
  endtask

  task automatic idle_cycle();
    @(negedge clock);
    mem_ack = 1'b0;
    drive_nop();
  endtask

  // Presents one instruction and, for a memop, plays the memory side with an
  // ack after 'delay' BUSY cycles.
  task automatic issue(input logic rd_m, input logic wr_m, input logic [31:0] regb,
                       input logic sel, input logic [4:0] rdst, input logic wen,
                       input logic [31:0] wbv, input int delay, input logic [31:0] rdata);
    logic [31:0] exp_val;
    int          stalls;
    @(negedge clock);
    mem_ack           = 1'b0;
    id_mem_readmem    = rd_m;
    id_mem_writemem   = wr_m;
    id_mem_regb       = regb;
    id_mem_selwsource = sel;
    id_mem_regdest    = rdst;
    id_mem_writereg   = wen;
    id_mem_wbvalue    = wbv;
    if (!(rd_m || wr_m)) begin
      if (wen) exp_q.push_back({rdst, wbv});
      #1;
      check_val("alu_stall", {31'b0, mem_stall}, 32'd0);
      check_val("alu_req", {31'b0, mem_req}, 32'd0);
    end else begin
      exp_val = (rd_m && !wr_m && sel) ? rdata : wbv;
      if (wen) exp_q.push_back({rdst, exp_val});
      #1;
      check_val("idle_req_low", {31'b0, mem_req}, 32'd0);
      stalls = mem_stall ? 1 : 0;
      for (int i = 0; i <= delay; i++) begin
        @(negedge clock);
        check_val("busy_req", {31'b0, mem_req}, 32'd1);
        check_val("busy_wb_bubble", {31'b0, mem_wb_writereg}, 32'd0);
        check_val("busy_buserr", {31'b0, mem_buserr}, 32'd0);
        if (i == 0) begin
          check_val("mem_wr", {31'b0, mem_wr}, {31'b0, wr_m});
          check_val("mem_addr", mem_addr, wbv);
          if (wr_m) check_val("mem_wdata", mem_wdata, regb);
        end
        if (i == delay) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata;
        end
        #1;
        if (mem_stall) stalls++;
      end
      check_val("stall_cycles", stalls, delay + 1);
    end
  endtask

  // Write-back monitor: every asserted mem_wb_writereg must match the next expected bundle.
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset && mem_wb_writereg) begin
        if (exp_q.size() == 0) begin
          check_val("wb_unexpected", {27'b0, mem_wb_regdest}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_val("wb_regdest", {27'b0, mem_wb_regdest}, {27'b0, e[36:32]});
          check_val("wb_value", mem_wb_value, e[31:0]);
          prev_pop = last_pop;
          last_pop = cyc;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clock);
    check_val("rst_req", {31'b0, mem_req}, 32'd0);
    check_val("rst_wb_value", mem_wb_value, 32'd0);
    check_val("rst_wb_writereg", {31'b0, mem_wb_writereg}, 32'd0);
    check_val("rst_addr", mem_addr, 32'd0);
    check_val("rst_buserr", {31'b0, mem_buserr}, 32'd0);
    reset = 1'b0;

    // ALU op, then a second ALU op with a different pattern
    issue(1'b0, 1'b0, 32'h0, 1'b0, 5'd5, 1'b1, 32'h0000_1234, 0, 32'h0);
    issue(1'b0, 1'b0, 32'h0, 1'b1, 5'd31, 1'b1, 32'hA5A5_5A5A, 0, 32'h0);
    // Load, ack 3 cycles after req
    issue(1'b1, 1'b0, 32'h0, 1'b1, 5'd7, 1'b1, 32'h0000_0040, 3, 32'hDEAD_BEEF);
    // Store, ack in first BUSY cycle
    issue(1'b0, 1'b1, 32'h0000_CAFE, 1'b0, 5'd2, 1'b0, 32'h0000_0080, 0, 32'h1111_1111);
    // Load with selwsource=0 writes back the address
    issue(1'b1, 1'b0, 32'h0, 1'b0, 5'd8, 1'b1, 32'h0000_0100, 1, 32'h2222_2222);
    // Read+write together behaves as a store returning the address
    issue(1'b1, 1'b1, 32'h0000_BEEF, 1'b1, 5'd9, 1'b1, 32'h0000_0200, 2, 32'h3333_3333);
    // Back-to-back memops, then load followed immediately by an ALU op
    issue(1'b0, 1'b1, 32'h1234_5678, 1'b0, 5'd0, 1'b0, 32'h0000_0300, 0, 32'h0);
    issue(1'b1, 1'b0, 32'h0, 1'b1, 5'd10, 1'b1, 32'h0000_0304, 0, 32'h0BAD_F00D);
    issue(1'b0, 1'b0, 32'h0, 1'b0, 5'd3, 1'b1, 32'h0000_0007, 0, 32'h0);
    idle_cycle();
    idle_cycle();
    check_val("b2b_gap", last_pop - prev_pop, 32'd1);

    // Reset in BUSY with a late ack
    @(negedge clock);
    id_mem_readmem    = 1'b1;
    id_mem_selwsource = 1'b1;
    id_mem_regdest    = 5'd12;
    id_mem_writereg   = 1'b1;
    id_mem_wbvalue    = 32'h0000_0400;
    @(negedge clock);
    check_val("pre_rst_req", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset     = 1'b0;
    drive_nop();
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_5555;
    #1;
    check_val("midrst_req", {31'b0, mem_req}, 32'd0);
    check_val("midrst_addr", mem_addr, 32'd0);
    check_val("midrst_wdata", mem_wdata, 32'd0);
    check_val("midrst_wr", {31'b0, mem_wr}, 32'd0);
    check_val("midrst_wb_value", mem_wb_value, 32'd0);
    check_val("midrst_stall", {31'b0, mem_stall}, 32'd0);
    idle_cycle();
    check_val("late_ack_req", {31'b0, mem_req}, 32'd0);
    check_val("late_ack_wb", {31'b0, mem_wb_writereg}, 32'd0);
    check_val("late_ack_value", mem_wb_value, 32'd0);
    issue(1'b0, 1'b0, 32'h0, 1'b0, 5'd6, 1'b1, 32'h0000_0066, 0, 32'h0);
    idle_cycle();

`ifdef MEM_TIMEOUT_EN
    begin
      int   stalls;
      logic released;
      stalls   = 0;
      released = 1'b0;
      @(negedge clock);
      id_mem_readmem    = 1'b1;
      id_mem_selwsource = 1'b1;
      id_mem_regdest    = 5'd13;
      id_mem_writereg   = 1'b1;
      id_mem_wbvalue    = 32'h0000_0500;
      #1;
      if (mem_stall) stalls++;
      for (int i = 0; i < 40 && !released; i++) begin
        @(negedge clock);
        #1;
        if (mem_stall) stalls++;
        else begin
          released = 1'b1;
          drive_nop();
        end
      end
      check_val("to_released", {31'b0, released}, 32'd1);
      check_val("to_stall_cycles", stalls, 32'd16);
      idle_cycle();
      check_val("to_buserr", {31'b0, mem_buserr}, 32'd1);
      check_val("to_req", {31'b0, mem_req}, 32'd0);
      check_val("to_wb", {31'b0, mem_wb_writereg}, 32'd0);
      idle_cycle();
      check_val("to_buserr_pulse", {31'b0, mem_buserr}, 32'd0);
    end
`else
    // Without the timeout a long wait simply completes.
    issue(1'b1, 1'b0, 32'h0, 1'b1, 5'd13, 1'b1, 32'h0000_0500, 20, 32'h7777_8888);
    idle_cycle();
`endif
    idle_cycle();
    idle_cycle();
    check_val("sb_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
